// File: rtl/dm_if.sv
// Request/response bundle between the MEM stage and the data-memory access unit.
interface dm_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  store_type;
  logic [2:0]  load_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] dm_data;
  logic [2:0]  load_type_o;
  logic [1:0]  addr_lo_o;
  logic        exc_adel;
  logic        exc_ades;

  modport master (
    output req_valid, req_we, store_type, load_type, addr, wdata,
    input  stall, resp_valid, dm_data, load_type_o, addr_lo_o, exc_adel, exc_ades
  );
  modport slave (
    input  req_valid, req_we, store_type, load_type, addr, wdata,
    output stall, resp_valid, dm_data, load_type_o, addr_lo_o, exc_adel, exc_ades
  );
endinterface

// File: rtl/dm_access_unit.sv
// MEM-stage data-memory access unit: word RAM with byte lanes, fixed wait states.
// Define DM_ALIGN_CHECK_EN to enable alignment/range exception detection.
module dm_access_unit #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  dm_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t r_state, w_next;

  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [1:0]            r_st;
  logic [2:0]            r_ldt;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_dm_data;
  logic [2:0]            r_lt;
  logic [1:0]            r_alo;
  logic                  r_adel, r_ades;

  logic                  w_accept, w_commit, w_err;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [3:0]            w_be;
  logic [31:0]           w_wd;

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd1);
  assign w_idx    = r_addr[ADDR_WIDTH+1:2];

`ifdef DM_ALIGN_CHECK_EN
  logic w_oor, w_half, w_word;
  assign w_oor  = |(bus.addr >> (ADDR_WIDTH + 2));
  assign w_half = bus.req_we ? (bus.store_type == 2'b01) : (bus.load_type[2:1] == 2'b01);
  assign w_word = bus.req_we ? bus.store_type[1] : bus.load_type[2];
  assign w_err  = w_oor || (w_half && bus.addr[0]) || (w_word && (bus.addr[1:0] != 2'b00));
`else
  logic w_unused_addr;
  assign w_unused_addr = ^bus.addr;
  assign w_err         = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = w_err ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.stall       = w_accept || (r_state == S_WAIT);
  assign bus.resp_valid  = (r_state == S_RESP);
  assign bus.dm_data     = r_dm_data;
  assign bus.load_type_o = r_lt;
  assign bus.addr_lo_o   = r_alo;
  assign bus.exc_adel    = r_adel;
  assign bus.exc_ades    = r_ades;

  always_comb begin
    w_be = 4'b1111;
    w_wd = r_wdata;
    case (r_st)
      2'b00: begin
        w_be = 4'b0001 << r_addr[1:0];
        w_wd = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be = 4'b0011 << {r_addr[1], 1'b0};
        w_wd = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Response fields change only when RESP is entered: at acceptance for an
  // erroring access, at commit otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_st      <= '0;
      r_ldt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_dm_data <= '0;
      r_lt      <= '0;
      r_alo     <= '0;
      r_adel    <= 1'b0;
      r_ades    <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= 4'(WAIT_CYCLES);
      r_we    <= bus.req_we;
      r_st    <= bus.store_type;
      r_ldt   <= bus.load_type;
      r_addr  <= bus.addr[ADDR_WIDTH+1:0];
      r_wdata <= bus.wdata;
      if (w_err) begin
        r_dm_data <= '0;
        r_lt      <= bus.load_type;
        r_alo     <= bus.addr[1:0];
        r_adel    <= !bus.req_we;
        r_ades    <= bus.req_we;
      end
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
      if (w_commit) begin
        r_dm_data <= r_we ? 32'd0 : r_mem[w_idx];
        r_lt      <= r_ldt;
        r_alo     <= r_addr[1:0];
        r_adel    <= 1'b0;
        r_ades    <= 1'b0;
      end
    end
  end

  // RAM is not reset; a reset on the commit edge drops the store.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_commit && r_we) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: byte-array memory model, per-cycle compare, directed vectors.
module tb_dm_access_unit;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int NB    = 4 * DEPTH;
  localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2;
  localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LW = 3'd4;

  logic clk = 1'b0;
  logic rst, rst3;
  always #5 clk = ~clk;

  dm_if b();
  dm_if b3();

  dm_access_unit #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) dut  (.i_clk(clk), .i_reset(rst),  .bus(b));
  dm_access_unit #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) dut3 (.i_clk(clk), .i_reset(rst3), .bus(b3));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed memory model, little-endian within a word.
  logic [7:0] mm [NB];

  function automatic void model(input logic we, input logic [1:0] st, input logic [2:0] lt,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] data, output logic exl, output logic exs);
    int sz, ea, base, wb;
    logic err;
    sz = we ? (st == 2'd0 ? 1 : st == 2'd1 ? 2 : 4) : (lt <= 3'd1 ? 1 : lt <= 3'd3 ? 2 : 4);
`ifdef DM_ALIGN_CHECK_EN
    err = (a >= NB) || (a % sz != 0);
`else
    err = 1'b0;
`endif
    ea   = int'(a % NB);
    base = ea - ea % sz;
    wb   = ea - ea % 4;
    data = 32'd0;
    exl  = err && !we;
    exs  = err && we;
    if (!err) begin
      if (we) for (int k = 0; k < sz; k++) mm[base + k] = wd[8*k +: 8];
      else    data = {mm[wb + 3], mm[wb + 2], mm[wb + 1], mm[wb]};
    end
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int m_acc = -100, m_lat = 0;
  logic [31:0] e_data, l_data = 0;
  logic [2:0]  e_lt, l_lt = 0;
  logic [1:0]  e_alo, l_alo = 0;
  logic        e_exl, e_exs, l_exl = 0, l_exs = 0;
  bit chk_en = 0;
  logic x_resp, x_stall;

  always @(negedge clk) begin
    if (chk_en) begin
      x_resp  = (cyc == m_acc + m_lat);
      x_stall = (cyc >= m_acc) && (cyc < m_acc + m_lat);
      if (x_resp) begin
        l_data = e_data; l_lt = e_lt; l_alo = e_alo; l_exl = e_exl; l_exs = e_exs;
      end
      chk("stall",       b.stall,       x_stall);
      chk("resp_valid",  b.resp_valid,  x_resp);
      chk("dm_data",     b.dm_data,     l_data);
      chk("load_type_o", b.load_type_o, l_lt);
      chk("addr_lo_o",   b.addr_lo_o,   l_alo);
      chk("exc_adel",    b.exc_adel,    l_exl);
      chk("exc_ades",    b.exc_ades,    l_exs);
    end
  end

  task automatic access(input logic we, input logic [1:0] st, input logic [2:0] lt,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] od, output logic [2:0] olt, output logic [1:0] oal,
                        output logic oxl, output logic oxs, output int ns, output int lat);
    @(posedge clk); #1;
    b.req_valid = 1'b1; b.req_we = we; b.store_type = st; b.load_type = lt;
    b.addr = a; b.wdata = wd;
    model(we, st, lt, a, wd, e_data, e_exl, e_exs);
    e_lt = lt; e_alo = a[1:0];
    m_lat = (e_exl || e_exs) ? 1 : 2;
    m_acc = cyc;
    ns = 0; lat = -1; od = 0; olt = 0; oal = 0; oxl = 0; oxs = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (b.stall) ns++;
      if (b.resp_valid) begin
        lat = t; od = b.dm_data; olt = b.load_type_o; oal = b.addr_lo_o;
        oxl = b.exc_adel; oxs = b.exc_ades;
        break;
      end
      @(posedge clk); #1;
      // request fields wander while waiting; the unit must ignore them
      b.req_valid = 1'b0; b.req_we = ~we; b.addr = $urandom; b.wdata = $urandom;
      b.load_type = 3'($urandom); b.store_type = 2'($urandom);
    end
    chk("latency", lat, m_lat);
  endtask

  task automatic go(input logic we, input logic [1:0] st, input logic [2:0] lt,
                    input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] d; logic [2:0] l; logic [1:0] al; logic x1, x2; int n, lat;
    access(we, st, lt, a, wd, d, l, al, x1, x2, n, lat);
  endtask

  task automatic acc3(input logic we, input logic [1:0] st, input logic [2:0] lt,
                      input logic [31:0] a, input logic [31:0] wd, output logic [31:0] od, output int lat);
    @(posedge clk); #1;
    b3.req_valid = 1'b1; b3.req_we = we; b3.store_type = st; b3.load_type = lt;
    b3.addr = a; b3.wdata = wd;
    lat = -1; od = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (b3.resp_valid) begin lat = t; od = b3.dm_data; break; end
      @(posedge clk); #1;
      b3.req_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] d; logic [2:0] l; logic [1:0] al; logic xl, xs; int ns, lat;
    rst = 1'b1; rst3 = 1'b1;
    b.req_valid = 0;  b.req_we = 0;  b.store_type = 0;  b.load_type = 0;  b.addr = 0;  b.wdata = 0;
    b3.req_valid = 0; b3.req_we = 0; b3.store_type = 0; b3.load_type = 0; b3.addr = 0; b3.wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    chk("rst stall", b.stall, 1'b0);
    chk("rst resp_valid", b.resp_valid, 1'b0);
    chk("rst dm_data", b.dm_data, 32'd0);
    chk("rst load_type_o", b.load_type_o, 3'd0);
    chk("rst addr_lo_o", b.addr_lo_o, 2'd0);
    chk("rst exc", {b.exc_adel, b.exc_ades}, 2'b00);
    chk_en = 1;

    go(1'b1, SW, LW, 32'h10, 32'h12345678);
    access(1'b0, SW, LW, 32'h10, 32'h0, d, l, al, xl, xs, ns, lat);
    chk("lw10 data", d, 32'h12345678);
    chk("lw10 stall cycles", ns, 2);
    chk("lw10 latency", lat, 2);

    go(1'b1, SB, LB, 32'h13, 32'hFFFFFFAB);
    access(1'b0, SW, LW, 32'h10, 32'h0, d, l, al, xl, xs, ns, lat);
    chk("sb13 word", d, 32'hAB345678);
    access(1'b0, SW, LB, 32'h13, 32'h0, d, l, al, xl, xs, ns, lat);
    chk("lb13 load_type_o", l, 3'b000);
    chk("lb13 addr_lo_o", al, 2'b11);

    go(1'b1, SH, LB, 32'h12, 32'h1234BEEF);
    access(1'b0, SW, LW, 32'h10, 32'h0, d, l, al, xl, xs, ns, lat);
    chk("sh12 word", d, 32'hBEEF5678);

    go(1'b1, SW, LW, 32'h0,  32'hCAFEF00D);
    go(1'b1, SW, LW, 32'h4,  32'h44444444);
    go(1'b1, SW, LW, 32'h20, 32'h01020304);
    go(1'b1, SW, LW, 32'h3FC, 32'h0BADF00D);
    go(1'b0, SW, LBU, 32'h11, 32'h0);
    go(1'b0, SW, LHU, 32'h12, 32'h0);
    go(1'b0, SW, LH,  32'h02, 32'h0);

    access(1'b0, SW, LW, 32'h11, 32'h0, d, l, al, xl, xs, ns, lat);
`ifdef DM_ALIGN_CHECK_EN
    chk("lw11 adel", xl, 1'b1);
    chk("lw11 data", d, 32'h0);
    chk("lw11 latency", lat, 1);
    chk("lw11 stall cycles", ns, 1);
`else
    chk("lw11 adel", xl, 1'b0);
    chk("lw11 data", d, 32'hBEEF5678);
`endif

    access(1'b1, SW, LW, 32'h22, 32'hDEADBEEF, d, l, al, xl, xs, ns, lat);
    access(1'b0, SW, LW, 32'h20, 32'h0, d, l, al, xl, xs, ns, lat);
`ifdef DM_ALIGN_CHECK_EN
    chk("lw20 after bad sw", d, 32'h01020304);
`else
    chk("lw20 after sw22", d, 32'hDEADBEEF);
`endif

    access(1'b0, SW, LW, 32'h400, 32'h0, d, l, al, xl, xs, ns, lat);
`ifdef DM_ALIGN_CHECK_EN
    chk("lw400 adel", xl, 1'b1);
`else
    chk("lw400 wrap", d, 32'hCAFEF00D);
`endif
    go(1'b1, SW, LW, 32'h404, 32'h00000077);
    go(1'b0, SW, LW, 32'h4, 32'h0);
    go(1'b0, SW, LH, 32'h13, 32'h0);
    go(1'b1, SB, LW, 32'h3FF, 32'h0000005A);
    go(1'b0, SW, LW, 32'h3FC, 32'h0);
    go(1'b1, SH, LW, 32'h3FD, 32'h00009999);
    go(1'b0, SW, LW, 32'h3FC, 32'h0);

    // reset in the middle of a WAIT_CYCLES=3 store
    acc3(1'b1, SW, LW, 32'h40, 32'h11111111, d, lat);
    chk("w3 store latency", lat, 4);
    acc3(1'b0, SW, LW, 32'h40, 32'h0, d, lat);
    chk("w3 lw40 data", d, 32'h11111111);
    chk("w3 lw40 latency", lat, 4);
    @(posedge clk); #1;
    b3.req_valid = 1'b1; b3.req_we = 1'b1; b3.store_type = SW; b3.load_type = LW;
    b3.addr = 32'h41; b3.wdata = 32'h55;
    @(posedge clk); #1 b3.req_valid = 1'b0;
    @(posedge clk); #1 rst3 = 1'b1;
    @(posedge clk); #1 rst3 = 1'b0;
    @(negedge clk);
    chk("w3 rst stall", b3.stall, 1'b0);
    chk("w3 rst dm_data", b3.dm_data, 32'd0);
    chk("w3 rst load_type_o", b3.load_type_o, 3'd0);
    chk("w3 rst addr_lo_o", b3.addr_lo_o, 2'd0);
    chk("w3 rst exc", {b3.exc_adel, b3.exc_ades}, 2'b00);
    for (int i = 0; i < 5; i++) begin
      chk("w3 no resp after rst", b3.resp_valid, 1'b0);
      @(negedge clk);
    end
    b3.addr = 32'h40;
    acc3(1'b0, SW, LW, 32'h40, 32'h0, d, lat);
    chk("w3 store dropped", d, 32'h11111111);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
